// File: rtl/vec_reg_file.sv
// Vector register file: NREGS x (LANES*ELEM_W), two async read ports, one masked write port,
// optional write-to-read bypass and a sequenced clear engine.
module vec_reg_file #(
    parameter int LANES  = 6,
    parameter int ELEM_W = 8,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_req,
    output logic                      clr_bsy,
    input  logic                      we3,
    input  logic [LANES-1:0]          wmask3,
    input  logic [ADDR_W-1:0]         ra3,
    input  logic [LANES*ELEM_W-1:0]   wd3,
    output logic                      wr_drop,
    input  logic [ADDR_W-1:0]         ra1,
    input  logic [ADDR_W-1:0]         ra2,
    output logic [LANES*ELEM_W-1:0]   rd1,
    output logic [LANES*ELEM_W-1:0]   rd2
);

    localparam int RW = LANES * ELEM_W;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [ADDR_W:0]   LIM  = (ADDR_W + 1)'(NREGS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

    logic [RW-1:0]     r_rf [NREGS];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_drop;

    logic          w_busy;
    logic          w_ok1;
    logic          w_ok2;
    logic          w_ok3;
    logic          w_wr_any;
    logic          w_wr_en;
    logic [RW-1:0] w_bmask;
    logic [RW-1:0] w_old3;
    logic [RW-1:0] w_merged;
    logic [RW-1:0] w_arr1;
    logic [RW-1:0] w_arr2;

    assign w_busy   = (r_state == S_CLEAR);
    assign w_ok1    = {1'b0, ra1} < LIM;
    assign w_ok2    = {1'b0, ra2} < LIM;
    assign w_ok3    = {1'b0, ra3} < LIM;
    assign w_wr_any = we3 && (|wmask3);
    assign w_wr_en  = we3 && !w_busy && w_ok3;

    // Lane mask expanded to a bit mask for the read-modify-write merge
    for (genvar g = 0; g < LANES; g++) begin : g_mask
        assign w_bmask[g*ELEM_W +: ELEM_W] = {ELEM_W{wmask3[g]}};
    end

    assign w_old3   = w_ok3 ? r_rf[ra3] : '0;
    assign w_merged = (w_old3 & ~w_bmask) | (wd3 & w_bmask);
    assign w_arr1   = w_ok1 ? r_rf[ra1] : '0;
    assign w_arr2   = w_ok2 ? r_rf[ra2] : '0;

    assign rd1 = (BYPASS != 0 && w_wr_en && ra3 == ra1) ? w_merged : w_arr1;
    assign rd2 = (BYPASS != 0 && w_wr_en && ra3 == ra2) ? w_merged : w_arr2;

    assign clr_bsy = w_busy;
    assign wr_drop = r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_wr_any && (w_busy || !w_ok3);
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sweep and write never target the same edge: writes are blocked while busy
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                r_rf[i] <= '0;
            end else if (w_busy && r_cnt == ADDR_W'(i)) begin
                r_rf[i] <= '0;
            end else if (w_wr_en && ra3 == ADDR_W'(i)) begin
                r_rf[i] <= w_merged;
            end
        end
    end

endmodule
